// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command front-end for an 8-bit registered ALU.
// Requests are queued in a small FIFO and issued one at a time. Operands are
// held on the ALU inputs for the select-dependent latency. The result is then
// captured and returned with its tag on a valid/ready response channel.
module alu_op_sequencer #(
  parameter int DEPTH    = 4,
  parameter int TAG_W    = 4,
  parameter int BASE_LAT = 1,
  parameter int MUL_LAT  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  // request channel
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [7:0]               req_a,
  input  logic [7:0]               req_b,
  input  logic [3:0]               req_sel,
  input  logic [TAG_W-1:0]         req_tag,
  // ALU drive / return
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  output logic [3:0]               alu_sel,
  input  logic [7:0]               alu_out,
  input  logic                     alu_carry,
  // response channel
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_result,
  output logic                     rsp_carry,
  output logic [TAG_W-1:0]         rsp_tag,
  // status
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int MAX_LAT = (MUL_LAT > BASE_LAT) ? MUL_LAT : BASE_LAT;
  localparam int LAT_W   = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

  // ALU select that uses the longer multiply latency
  localparam logic [3:0] SEL_MUL = 4'd2;
  localparam logic [3:0] SEL_ADD = 4'd0;

  typedef struct packed {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [3:0]       sel;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------
  entry_t              mem_reg [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0]    count_reg;

  state_t              state_reg;
  logic [LAT_W-1:0]    lat_cnt_reg;
  logic [TAG_W-1:0]    tag_hold_reg;

  logic [7:0]          alu_a_reg;
  logic [7:0]          alu_b_reg;
  logic [3:0]          alu_sel_reg;

  logic                rsp_valid_reg;
  logic [7:0]          rsp_result_reg;
  logic                rsp_carry_reg;
  logic [TAG_W-1:0]    rsp_tag_reg;

  logic                push;
  logic                pop;
  logic [DEPTH-1:0]    wr_en;
  entry_t              req_entry;
  entry_t              head_entry;

  // ---------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------
  // Ready depends only on registered occupancy; a same-cycle pop does not
  // relieve it, so a full FIFO always stalls the requester for one cycle.
  assign req_ready  = (count_reg < CNT_W'(DEPTH));
  assign push       = req_valid && req_ready;
  assign pop        = (state_reg == IDLE) && (count_reg != '0);

  assign req_entry  = '{a: req_a, b: req_b, sel: req_sel, tag: req_tag};

  // The FIFO is a few entries deep, so the head is read straight out of the
  // register file; this lets the pop edge load the ALU operands directly.
  assign head_entry = mem_reg[rd_ptr_reg];

  // One write strobe per entry, decoded from the write pointer
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
  end

  // Entry storage: write the accepted request into the slot under wr_ptr
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        mem_reg[i] <= req_entry;
      end
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Issue / wait / respond sequencer
  // ---------------------------------------------------------------------
  // Issue the head op, wait out the ALU latency, then hold the response
  // until the consumer takes it. The extra WAIT edge after the counter
  // expires covers the ALU's own output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      lat_cnt_reg    <= '0;
      tag_hold_reg   <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_sel_reg    <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_result_reg <= '0;
      rsp_carry_reg  <= 1'b0;
      rsp_tag_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pop) begin
            alu_a_reg    <= head_entry.a;
            alu_b_reg    <= head_entry.b;
            alu_sel_reg  <= head_entry.sel;
            tag_hold_reg <= head_entry.tag;
            lat_cnt_reg  <= (head_entry.sel == SEL_MUL) ? LAT_W'(MUL_LAT)
                                                        : LAT_W'(BASE_LAT);
            state_reg    <= WAIT;
          end
        end

        WAIT: begin
          if (lat_cnt_reg != '0) begin
            lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
          end else begin
            rsp_result_reg <= alu_out;
            // Only the add select produces a meaningful carry
            rsp_carry_reg  <= (alu_sel_reg == SEL_ADD) ? alu_carry : 1'b0;
            rsp_tag_reg    <= tag_hold_reg;
            rsp_valid_reg  <= 1'b1;
            state_reg      <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign alu_sel    = alu_sel_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_result = rsp_result_reg;
  assign rsp_carry  = rsp_carry_reg;
  assign rsp_tag    = rsp_tag_reg;
  assign fifo_count = count_reg;
  assign busy       = (state_reg != IDLE) || (count_reg != '0);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed, table-driven bench for alu_op_sequencer.
// A small registered ALU stand-in sits on the alu_* pins. It has a one-stage
// path for ordinary selects and a two-stage path for multiply. Its carry pin
// is forced high on non-add selects so that the carry masking is exercised.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

  localparam int DEPTH    = 4;
  localparam int TAG_W    = 4;
  localparam int BASE_LAT = 1;
  localparam int MUL_LAT  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [7:0]       req_a = '0;
  logic [7:0]       req_b = '0;
  logic [3:0]       req_sel = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [3:0]       alu_sel;
  logic [7:0]       alu_out;
  logic             alu_carry;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [7:0]       rsp_result;
  logic             rsp_carry;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;
  logic [2:0]       fifo_count;

  int tests = 0;
  int fails = 0;

  alu_op_sequencer #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .BASE_LAT(BASE_LAT), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_tag(rsp_tag),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // ---------------- ALU stand-in ----------------
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] s);
    case (s)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a - b};
      4'd8:    return {1'b0, a & b};
      4'd9:    return {1'b0, a | b};
      4'd10:   return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  logic [7:0]  base_q;
  logic        carry_q;
  logic [7:0]  mul1_q;
  logic [7:0]  mul2_q;
  logic [8:0]  base_f;
  logic [15:0] prod;

  assign base_f = alu_f(alu_a, alu_b, alu_sel);
  assign prod   = {8'd0, alu_a} * {8'd0, alu_b};

  always_ff @(posedge clk) begin
    base_q  <= base_f[7:0];
    carry_q <= (alu_sel == 4'd0) ? base_f[8] : 1'b1;
    mul1_q  <= prod[7:0];
    mul2_q  <= mul1_q;
  end

  assign alu_out   = (alu_sel == 4'd2) ? mul2_q : base_q;
  assign alu_carry = carry_q;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic [3:0] tag;
    logic [7:0] exp_res;
    logic       exp_carry;
    int         exp_lat;   // edges from the accepting edge to rsp_valid seen high
  } vec_t;

  vec_t vecs [10];

  // Single request into an idle, empty block with rsp_ready held high
  task automatic run_vec(input int idx, input vec_t v);
    int  edges;
    bit  got;
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_a = v.a; req_b = v.b; req_sel = v.sel; req_tag = v.tag;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    edges = 0;
    got = 1'b0;
    while (!got && edges < 40) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
      if (edges == 1) begin
        check($sformatf("v%0d_issue_sel", idx), alu_sel, v.sel);
        check($sformatf("v%0d_issue_a", idx), alu_a, v.a);
      end
      if (rsp_valid) got = 1'b1;
    end
    check($sformatf("v%0d_latency", idx), edges, v.exp_lat);
    check($sformatf("v%0d_result", idx), rsp_result, v.exp_res);
    check($sformatf("v%0d_carry", idx), rsp_carry, v.exp_carry);
    check($sformatf("v%0d_tag", idx), rsp_tag, v.tag);
    $display("[TB] vec %0d sel=%0d a=%0d b=%0d tag=%0d -> result=%0d carry=%0d lat=%0d",
             idx, v.sel, v.a, v.b, rsp_tag, rsp_result, rsp_carry, edges);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("v%0d_valid_drop", idx), rsp_valid, 1'b0);
    check($sformatf("v%0d_busy_idle", idx), busy, 1'b0);
    check($sformatf("v%0d_sel_hold", idx), alu_sel, v.sel);
  endtask

  initial begin
    int accepted;
    int n;
    int cyc;
    int seen;

    vecs[0] = '{8'd200, 8'd100, 4'd0,  4'd3,  8'd44,  1'b1, 3};
    vecs[1] = '{8'd12,  8'd10,  4'd2,  4'd5,  8'd120, 1'b0, 4};
    vecs[2] = '{8'd5,   8'd9,   4'd1,  4'd1,  8'd252, 1'b0, 3};
    vecs[3] = '{8'd255, 8'd1,   4'd0,  4'd7,  8'd0,   1'b1, 3};
    vecs[4] = '{8'd1,   8'd2,   4'd0,  4'd2,  8'd3,   1'b0, 3};
    vecs[5] = '{8'd16,  8'd16,  4'd2,  4'd9,  8'd0,   1'b0, 4};
    vecs[6] = '{8'hF0,  8'h3C,  4'd8,  4'd10, 8'h30,  1'b0, 3};
    vecs[7] = '{8'hFF,  8'h0F,  4'd10, 4'd15, 8'hF0,  1'b0, 3};
    vecs[8] = '{8'h5A,  8'h00,  4'd15, 4'd4,  8'h5A,  1'b0, 3};
    vecs[9] = '{8'd7,   8'd8,   4'd2,  4'd6,  8'd56,  1'b0, 4};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_fifo_count", fifo_count, 3'd0);
    check("rst_alu_sel", alu_sel, 4'd0);
    check("rst_alu_a", alu_a, 8'd0);
    check("rst_rsp_result", rsp_result, 8'd0);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;

    // ---- single-op vectors ----
    for (int i = 0; i < 10; i++) begin
      run_vec(i, vecs[i]);
    end

    // ---- backpressure: 7 back-to-back requests with rsp_ready low ----
    @(negedge clk);
    rsp_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 7; i++) begin
      req_valid = 1'b1;
      req_a = 8'(i); req_b = 8'd1; req_sel = 4'd0; req_tag = 4'(i);
      if (req_ready) accepted++;
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("bp_accepted", accepted, 5);
    check("bp_fifo_full", fifo_count, 3'd4);
    check("bp_req_ready", req_ready, 1'b0);

    // ---- response held stable while the consumer stalls ----
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", rsp_valid, 1'b1);
      check("stall_result", rsp_result, 8'd1);
      check("stall_tag", rsp_tag, 4'd0);
      check("stall_no_pop", fifo_count, 3'd4);
      @(posedge clk);
      @(negedge clk);
    end

    // ---- drain in order ----
    rsp_ready = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 5 && cyc < 200) begin
      if (rsp_valid) begin
        check("drain_tag", rsp_tag, 4'(n));
        check("drain_result", rsp_result, 8'(n + 1));
        $display("[TB] drain rsp tag=%0d result=%0d", rsp_tag, rsp_result);
        n++;
      end
      if (n < 5) begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    check("drain_count", n, 5);
    @(posedge clk);
    @(negedge clk);
    check("drain_valid_low", rsp_valid, 1'b0);
    check("drain_busy_low", busy, 1'b0);
    check("drain_fifo_empty", fifo_count, 3'd0);

    // ---- reset while in WAIT with 3 entries queued ----
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_a = 8'(i + 3); req_b = 8'(i + 4);
      req_sel = (i == 0) ? 4'd2 : 4'd0;
      req_tag = 4'(8 + i);
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("prerst_fifo_count", fifo_count, 3'd3);
    check("prerst_busy", busy, 1'b1);
    check("prerst_alu_sel", alu_sel, 4'd2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] mid-op reset applied");
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_fifo_count", fifo_count, 3'd0);
    check("midrst_alu_sel", alu_sel, 4'd0);
    check("midrst_busy", busy, 1'b0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("midrst_no_rsp", seen, 0);
    run_vec(10, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
